sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameters (name, default, meaning): ADDR_BITS, 8, decoded address width; memory depth is 2^ADDR_BITS bytes.
REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1, single clock; all state changes on posedge clk.
- reset, input, 1, asynchronous, active-high.
- sram_addr, input, 21, byte address from the controller.
- sram_ce, input, 1, chip enable, active low.
- sram_we, input, 1, write enable, active low.
- sram_oe, input, 1, output enable, active low.
- sram_data, inout, 8, bidirectional byte bus.
- clear_flags, input, 1, synchronous clear of the sticky error flags.
- wr_count, output, 16, bytes written since reset.
- rd_count, output, 16, bytes read since reset.
- range_err, output, 1, sticky: access to an address at or above 2^ADDR_BITS.
- contend_err, output, 1, sticky: ce, we and oe all low together.
- turn_err, output, 1, sticky: read requested in the cycle after a write.
- dbg_addr, input, ADDR_BITS, backdoor read address.
- dbg_data, output, 8, combinational mem[dbg_addr]; has no side effects.

Function
REQ-003 Byte memory of 2^ADDR_BITS entries, indexed by sram_addr[ADDR_BITS-1:0].
REQ-004 Access decode, evaluated each cycle from the current inputs:
- IDLE: ce=1, whatever the values of we and oe.
- WR: ce=0, we=0.
- RD: ce=0, we=1, oe=0.
- NOP: ce=0, we=1, oe=1.
REQ-005 WR handling:
- On the posedge, mem[addr] <= sram_data.
- sram_data is never driven by this block during WR.
REQ-006 RD handling: sram_data is driven combinationally with mem[addr] in the same cycle (zero latency), so a controller can sample it within the access cycle.
REQ-007 sram_data is high-Z in every cycle that is not a qualifying RD, and always high-Z while reset=1.
REQ-008 Contention (ce=we=oe=0):
- Treated as WR, because we overrides oe.
- The bus is not driven.
- contend_err is set.
REQ-009 Out-of-range access (WR or RD with sram_addr[20:ADDR_BITS] nonzero):
- range_err is set.
- A WR leaves memory unchanged.
- A RD drives 8'h00.
REQ-010 last_op register:
- Records the decoded access (IDLE/WR/RD/NOP) at each posedge.
- Resets to IDLE.
REQ-011 Turnaround: if last_op=WR and the current decode is RD:
- The bus is not driven; sram_data stays high-Z.
- turn_err is set.
- rd_count does not increment.
REQ-012 wr_count increments by 1 at each posedge whose decode is WR, including out-of-range and contention cases; it saturates at 16'hFFFF.
REQ-013 rd_count increments by 1 at each posedge whose decode is a driven RD, including out-of-range; it saturates at 16'hFFFF.
REQ-014 Sticky flags:
- Each error flag sets on the posedge following its condition.
- clear_flags=1 clears all three on the posedge.
- If a new error occurs in the same cycle as clear_flags, that flag ends the cycle set; the other flags clear.
REQ-015 A controller performing two consecutive single-cycle byte writes (addr, addr+1) followed by an IDLE cycle and two single-cycle reads returns the same bytes in order, with no errors flagged.

Reset
REQ-016 While reset is high:
- All memory entries = 8'h00.
- wr_count = rd_count = 0.
- range_err = contend_err = turn_err = 0.
- last_op = IDLE.
- sram_data is high-Z.
REQ-017 A reset asserted mid-access aborts it immediately: a write in progress does not commit, and bus drive stops combinationally. After deassertion, the first access is decoded normally.

Verification
REQ-018 The bench shall cover these directed scenarios:
- Write 8'hA5 to 0x10, then 8'h3C to 0x11, IDLE, read 0x10 then 0x11 -> bus shows A5 then 3C; wr_count=2, rd_count=2; no flags set.
- ce=we=oe=0 at addr 0x20 with bus=8'h77 -> mem[0x20]=77 (via dbg_data); bus undriven; contend_err=1; wr_count=1.
- Write to 0x000100 with ADDR_BITS=8 -> mem unchanged, range_err=1; a subsequent read of 0x000100 -> bus=00, rd_count=1.
- WR at 0x05 immediately followed by RD at 0x05 -> bus high-Z during the RD, turn_err=1, rd_count unchanged; a RD after an IDLE cycle returns the written byte.
- clear_flags asserted together with a new contention -> contend_err stays 1, range_err and turn_err become 0; 65540 writes -> wr_count=FFFF.
- Reset pulse during a RD -> bus goes high-Z within the cycle, all memory reads 00, counters 0.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: byte-wide asynchronous SRAM target with zero-latency reads,
// access counters and sticky protocol-error flags.
module sram_responder #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [20:0]          sram_addr,
    input  logic                 sram_ce,
    input  logic                 sram_we,
    input  logic                 sram_oe,
    inout  wire  [7:0]           sram_data,
    input  logic                 clear_flags,
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count,
    output logic                 range_err,
    output logic                 contend_err,
    output logic                 turn_err,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [7:0]           dbg_data
);
    typedef enum logic [1:0] {IDLE, WR, RD, NOP} op_t;
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem [DEPTH];
    op_t op, last_op;
    logic [ADDR_BITS-1:0] idx;
    logic in_range, turn, drive, contend, range_hit;

    // we overrides oe, so contention decodes as a write
    always_comb begin
        op = sram_ce ? IDLE : !sram_we ? WR : !sram_oe ? RD : NOP;
        idx = sram_addr[ADDR_BITS-1:0];
        in_range = (sram_addr >> ADDR_BITS) == 21'd0;
        turn = op == RD && last_op == WR;
        drive = op == RD && !turn && !reset;
        contend = op == WR && !sram_oe;
        range_hit = (op == WR || op == RD) && !in_range;
    end

    assign sram_data = drive ? (in_range ? mem[idx] : 8'h00) : 8'hzz;
    assign dbg_data = mem[dbg_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            last_op <= IDLE;
            wr_count <= 16'd0;
            rd_count <= 16'd0;
            range_err <= 1'b0;
            contend_err <= 1'b0;
            turn_err <= 1'b0;
        end else begin
            if (op == WR && in_range) mem[idx] <= sram_data;
            last_op <= op;
            if (op == WR && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (drive && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            // a new error wins over a simultaneous clear
            range_err <= range_hit || (range_err && !clear_flags);
            contend_err <= contend || (contend_err && !clear_flags);
            turn_err <= turn || (turn_err && !clear_flags);
        end
    end
endmodule
